// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer: host-side JTAG master. Takes TLR/IR/DR/idle commands
// on a valid/ready port, generates TCK from the system clock, walks the TAP
// through its state sequence and returns the TDO word captured during a scan.
module jtag_scan_sequencer #(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmdValid,
    output logic              o_cmdReady,
    input  logic [1:0]        i_cmdOp,
    input  logic [5:0]        i_cmdLen,
    input  logic [DATA_W-1:0] i_cmdData,
    output logic              o_rspValid,
    input  logic              i_rspReady,
    output logic [DATA_W-1:0] o_rspData,
    output logic              o_tck,
    output logic              o_tms,
    output logic              o_tdi,
    input  logic              i_tdo,
    output logic [3:0]        o_tapState,
    output logic              o_busy
);
    localparam logic [1:0] OP_TLR  = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_IDLE = 2'b11;

    localparam int              PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [5:0]      LEN_MAX = 6'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_HEADER, S_SHIFT, S_TRAILER, S_RUNIDLE, S_RESP
    } state_t;

    state_t            r_state;
    logic [PH_W-1:0]   r_phCnt;
    logic [6:0]        r_step;
    logic [1:0]        r_op;
    logic [5:0]        r_len;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_rsp;
    logic              r_tck;
    logic              r_tms;
    logic              r_tdi;
    logic              r_cmdReady;
    logic              r_rspValid;
    logic              r_busy;
    logic [3:0]        r_tap;

    logic              w_phEnd;
    logic [6:0]        w_lastStep;
    state_t            w_nState;
    logic [6:0]        w_nStep;
    state_t            w_cmdState;
    logic [5:0]        w_lenClamp;
    logic [DATA_W-1:0] w_dataShift;
    logic [DATA_W-1:0] w_bitMask;

    // Standard TAP transition graph in the team encoding
    function automatic logic [3:0] tapNext(input logic [3:0] s, input logic tms);
        case (s)
            4'hF: tapNext = tms ? 4'hF : 4'hC;
            4'hC: tapNext = tms ? 4'h7 : 4'hC;
            4'h7: tapNext = tms ? 4'h4 : 4'h6;
            4'h6: tapNext = tms ? 4'h1 : 4'h2;
            4'h2: tapNext = tms ? 4'h1 : 4'h2;
            4'h1: tapNext = tms ? 4'h5 : 4'h3;
            4'h3: tapNext = tms ? 4'h0 : 4'h3;
            4'h0: tapNext = tms ? 4'h5 : 4'h2;
            4'h5: tapNext = tms ? 4'h7 : 4'hC;
            4'h4: tapNext = tms ? 4'hF : 4'hE;
            4'hE: tapNext = tms ? 4'h9 : 4'hA;
            4'hA: tapNext = tms ? 4'h9 : 4'hA;
            4'h9: tapNext = tms ? 4'hD : 4'hB;
            4'hB: tapNext = tms ? 4'h8 : 4'hB;
            4'h8: tapNext = tms ? 4'hD : 4'hA;
            4'hD: tapNext = tms ? 4'h7 : 4'hC;
        endcase
    endfunction

    // TMS value for TCK period 'step' of a given sequencer state
    function automatic logic tmsFor(input state_t st, input logic [1:0] op,
                                    input logic [6:0] step, input logic [5:0] len);
        case (st)
            S_INIT:    tmsFor = (step != 7'd5);
            S_HEADER:  tmsFor = (op == OP_IR) ? (step < 7'd2) : (step == 7'd0);
            S_SHIFT:   tmsFor = (step == {1'b0, len});
            S_TRAILER: tmsFor = (step == 7'd0);
            default:   tmsFor = 1'b0;
        endcase
    endfunction

    assign w_phEnd     = (r_phCnt == PH_LAST);
    assign w_lenClamp  = (i_cmdLen > LEN_MAX) ? LEN_MAX : i_cmdLen;
    assign w_dataShift = r_data >> 1;
    assign w_bitMask   = DATA_W'(1) << r_step;

    // Index of the final TCK period in each TCK-driving state
    always_comb begin
        w_lastStep = 7'd0;
        case (r_state)
            S_INIT:              w_lastStep = 7'd5;
            S_HEADER:            w_lastStep = (r_op == OP_IR) ? 7'd3 : 7'd2;
            S_SHIFT, S_RUNIDLE:  w_lastStep = {1'b0, r_len};
            S_TRAILER:           w_lastStep = 7'd1;
            default:             w_lastStep = 7'd0;
        endcase
    end

    // State and step that follow the TCK period now ending
    always_comb begin
        w_nState = r_state;
        w_nStep  = r_step + 7'd1;
        if (r_step == w_lastStep) begin
            w_nStep = 7'd0;
            case (r_state)
                S_INIT:    w_nState = S_IDLE;
                S_HEADER:  w_nState = S_SHIFT;
                S_SHIFT:   w_nState = S_TRAILER;
                S_TRAILER: w_nState = S_RESP;
                S_RUNIDLE: w_nState = S_IDLE;
                default:   w_nState = r_state;
            endcase
        end
    end

    // First state entered for a newly accepted command
    always_comb begin
        case (i_cmdOp)
            OP_TLR:  w_cmdState = S_INIT;
            OP_IDLE: w_cmdState = S_RUNIDLE;
            default: w_cmdState = S_HEADER;
        endcase
    end

    // Sequencer FSM: TCK phase timing, TMS/TDI launch, TDO capture, TAP mirror
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_INIT;
            r_phCnt    <= '0;
            r_step     <= 7'd0;
            r_op       <= OP_TLR;
            r_len      <= 6'd0;
            r_data     <= '0;
            r_rsp      <= '0;
            r_tck      <= 1'b0;
            r_tms      <= 1'b1;
            r_tdi      <= 1'b0;
            r_cmdReady <= 1'b0;
            r_rspValid <= 1'b0;
            r_busy     <= 1'b1;
            r_tap      <= 4'hF;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmdValid && r_cmdReady) begin
                        r_state    <= w_cmdState;
                        r_op       <= i_cmdOp;
                        r_len      <= w_lenClamp;
                        r_data     <= i_cmdData;
                        r_rsp      <= '0;
                        r_phCnt    <= '0;
                        r_step     <= 7'd0;
                        r_tck      <= 1'b0;
                        r_tms      <= tmsFor(w_cmdState, i_cmdOp, 7'd0, w_lenClamp);
                        r_tdi      <= 1'b0;
                        r_cmdReady <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (i_rspReady) begin
                        r_state    <= S_IDLE;
                        r_rspValid <= 1'b0;
                        r_cmdReady <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    if (!w_phEnd) begin
                        r_phCnt <= r_phCnt + 1'b1;
                    end else begin
                        r_phCnt <= '0;
                        if (!r_tck) begin
                            r_tck <= 1'b1;
                            r_tap <= tapNext(r_tap, r_tms);
                            if (r_state == S_SHIFT) begin
                                r_rsp <= i_tdo ? (r_rsp | w_bitMask) : (r_rsp & ~w_bitMask);
                            end
                        end else begin
                            r_tck   <= 1'b0;
                            r_state <= w_nState;
                            r_step  <= w_nStep;
                            r_tms   <= tmsFor(w_nState, r_op, w_nStep, r_len);
                            if (w_nState == S_SHIFT) begin
                                r_tdi <= (r_state == S_SHIFT) ? w_dataShift[0] : r_data[0];
                            end else begin
                                r_tdi <= 1'b0;
                            end
                            if (r_state == S_SHIFT) begin
                                r_data <= w_dataShift;
                            end
                            if (w_nState == S_IDLE) begin
                                r_cmdReady <= 1'b1;
                                r_busy     <= 1'b0;
                            end
                            if (w_nState == S_RESP) begin
                                r_rspValid <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign o_cmdReady = r_cmdReady;
    assign o_rspValid = r_rspValid;
    assign o_rspData  = r_rsp;
    assign o_tck      = r_tck;
    assign o_tms      = r_tms;
    assign o_tdi      = r_tdi;
    assign o_tapState = r_tap;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// tb_jtag_scan_sequencer: randomized scoreboard bench for the JTAG scan
// sequencer. Expected TMS/TAP walks and response words are derived from the
// command rules; monitors compare them as the DUT produces TCK rises and
// responses.
module tb_jtag_scan_sequencer;
    localparam int CD = 2;
    localparam int DW = 32;

    localparam logic [1:0] OP_TLR  = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_DR   = 2'b10;
    localparam logic [1:0] OP_IDLE = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmdValid = 1'b0;
    logic [1:0]    cmdOp = 2'b00;
    logic [5:0]    cmdLen = 6'd0;
    logic [DW-1:0] cmdData = '0;
    logic          rspReady = 1'b0;
    logic          tdo;
    logic          tdoReg = 1'b0;
    int            tdoMode = 0;

    logic          cmdReady, rspValid, tck, tms, tdi, busy;
    logic [DW-1:0] rspData;
    logic [3:0]    tapState;

    typedef struct packed {
        logic       tms;
        logic [3:0] tap;
    } TckExp;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [31:0]   due;
        logic [31:0]   stall;
    } RspExp;

    TckExp       tckQ[$];
    RspExp       sbQ[$];
    int          nCmp = 0;
    int          nErr = 0;
    int unsigned cycCnt = 0;

    jtag_scan_sequencer #(.CLK_DIV(CD), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmdValid(cmdValid), .o_cmdReady(cmdReady),
        .i_cmdOp(cmdOp), .i_cmdLen(cmdLen), .i_cmdData(cmdData),
        .o_rspValid(rspValid), .i_rspReady(rspReady), .o_rspData(rspData),
        .o_tck(tck), .o_tms(tms), .o_tdi(tdi), .i_tdo(tdo),
        .o_tapState(tapState), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycCnt++;

    // TDO models: 0 = loopback, 1 = one-bit register clocked by TCK rise, 2 = inverted loopback
    always @(posedge tck) tdoReg <= tdi;
    assign tdo = (tdoMode == 1) ? tdoReg : (tdoMode == 2) ? ~tdi : tdi;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycCnt);
        end
    endtask

    task automatic pushTck(input logic m, input logic [3:0] s);
        TckExp e;
        e.tms = m;
        e.tap = s;
        tckQ.push_back(e);
    endtask

    task automatic waitReady();
        int k;
        k = 0;
        @(negedge clk);
        while (!cmdReady && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (!cmdReady) checkOutput("cmd_ready_timeout", cmdReady, 1);
    endtask

    // Reset for holdCycles edges, then check reset outputs and the INIT walk
    task automatic resetDut(input int holdCycles);
        int unsigned relCycle;
        @(negedge clk);
        rst = 1'b1;
        cmdValid = 1'b0;
        tckQ.delete();
        sbQ.delete();
        repeat (holdCycles) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_tck", tck, 0);
        checkOutput("rst_tms", tms, 1);
        checkOutput("rst_tdi", tdi, 0);
        checkOutput("rst_cmd_ready", cmdReady, 0);
        checkOutput("rst_rsp_valid", rspValid, 0);
        checkOutput("rst_rsp_data", rspData, 0);
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_tap", tapState, 4'hF);
        for (int i = 0; i < 5; i++) pushTck(1'b1, 4'hF);
        pushTck(1'b0, 4'hC);
        rst = 1'b0;
        relCycle = cycCnt;
        waitReady();
        checkOutput("init_ready_cycle", cycCnt - relCycle, 12 * CD);
        checkOutput("init_tap_end", tapState, 4'hC);
    endtask

    // Issue one command and record everything it is expected to produce
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] len,
                                 input logic [DW-1:0] data, input int mode, input int stall);
        int          lClamp;
        int          hdr;
        int          periods;
        int unsigned acc;
        logic [63:0] mask;
        logic [63:0] expData;
        RspExp       r;
        waitReady();
        checkOutput("busy_in_idle", busy, 0);
        tdoMode  = mode;
        cmdOp    = op;
        cmdLen   = len;
        cmdData  = data;
        cmdValid = 1'b1;
        acc      = cycCnt;
        lClamp   = (int'(len) > DW - 1) ? DW : int'(len) + 1;
        mask     = (64'd1 << lClamp) - 64'd1;
        hdr      = 0;
        periods  = 0;
        case (op)
            OP_TLR: begin
                pushTck(1, 4'h7); pushTck(1, 4'h4); pushTck(1, 4'hF);
                pushTck(1, 4'hF); pushTck(1, 4'hF); pushTck(0, 4'hC);
                periods = 6;
            end
            OP_IDLE: begin
                for (int i = 0; i < lClamp; i++) pushTck(0, 4'hC);
                periods = lClamp;
            end
            OP_IR: begin
                pushTck(1, 4'h7); pushTck(1, 4'h4); pushTck(0, 4'hE); pushTck(0, 4'hA);
                for (int i = 0; i < lClamp; i++)
                    if (i == lClamp - 1) pushTck(1, 4'h9); else pushTck(0, 4'hA);
                pushTck(1, 4'hD); pushTck(0, 4'hC);
                hdr = 4;
            end
            default: begin
                pushTck(1, 4'h7); pushTck(0, 4'h6); pushTck(0, 4'h2);
                for (int i = 0; i < lClamp; i++)
                    if (i == lClamp - 1) pushTck(1, 4'h1); else pushTck(0, 4'h2);
                pushTck(1, 4'h5); pushTck(0, 4'hC);
                hdr = 3;
            end
        endcase
        if (op == OP_IR || op == OP_DR) begin
            case (mode)
                1:       expData = ({32'd0, data} << 1) & mask;
                2:       expData = ~{32'd0, data} & mask;
                default: expData = {32'd0, data} & mask;
            endcase
            r.data  = expData[DW-1:0];
            r.due   = acc + 2 * CD * (hdr + lClamp + 2) + 1;
            r.stall = stall;
            sbQ.push_back(r);
        end
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
        cmdData  = $urandom;
        cmdLen   = 6'($urandom);
        checkOutput("ready_after_accept", cmdReady, 0);
        checkOutput("busy_after_accept", busy, 1);
        if (periods != 0) begin
            waitReady();
            checkOutput("op_done_cycle", cycCnt, acc + 2 * CD * periods + 1);
            checkOutput("op_tap_end", tapState, 4'hC);
        end
    endtask

    // TCK monitor: each rise pops the expected TMS and resulting TAP state
    int highCnt = 0;
    logic prevTck = 1'b0;
    always @(posedge clk) begin
        TckExp e;
        #1;
        if (rst) begin
            prevTck = 1'b0;
            highCnt = 0;
        end else begin
            if (tck && !prevTck) begin
                if (tckQ.size() == 0) begin
                    checkOutput("tck_unexpected_rise", tck, 0);
                end else begin
                    e = tckQ.pop_front();
                    checkOutput("tms_at_rise", tms, e.tms);
                    checkOutput("tap_after_rise", tapState, e.tap);
                end
                highCnt = 1;
            end else if (tck) begin
                highCnt++;
            end else if (prevTck) begin
                checkOutput("tck_high_len", highCnt, CD);
            end
            prevTck = tck;
        end
    end

    // Response monitor and host: checks latency, data, stability, then handshakes
    int waitCnt = 0;
    always @(negedge clk) begin
        RspExp e;
        if (rst || !rspValid) begin
            rspReady = 1'b0;
            waitCnt  = 0;
        end else if (sbQ.size() == 0) begin
            checkOutput("rsp_unexpected", rspValid, 0);
            rspReady = 1'b1;
        end else begin
            e = sbQ[0];
            if (waitCnt == 0) checkOutput("rsp_latency", cycCnt, e.due);
            checkOutput("rsp_data", rspData, e.data);
            checkOutput("cmd_ready_in_rsp", cmdReady, 0);
            if (waitCnt >= int'(e.stall)) begin
                rspReady = 1'b1;
                void'(sbQ.pop_front());
                waitCnt = 0;
            end else begin
                rspReady = 1'b0;
                waitCnt++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d comparisons made", nCmp);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        repeat (3) @(posedge clk);
        resetDut(1);

        applyStimulus(OP_IR, 6'd3, 32'h0000_0005, 1, 0);
        applyStimulus(OP_DR, 6'd31, 32'hDEAD_BEEF, 0, 0);
        applyStimulus(OP_DR, 6'd11, $urandom, 2, 20);
        applyStimulus(OP_IDLE, 6'd9, $urandom, 0, 0);
        applyStimulus(OP_TLR, 6'd0, $urandom, 0, 0);
        applyStimulus(OP_DR, 6'd63, $urandom, 0, 1);
        applyStimulus(OP_IR, 6'd0, 32'h0000_0001, 2, 0);

        applyStimulus(OP_DR, 6'd15, $urandom, 0, 0);
        repeat (2 * CD * (3 + 8)) @(negedge clk);
        resetDut(1);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            applyStimulus((r == 0) ? OP_TLR : (r <= 4) ? OP_IR : (r <= 8) ? OP_DR : OP_IDLE,
                          ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 63))
                                                      : 6'($urandom_range(0, 7)),
                          $urandom, $urandom_range(0, 2), $urandom_range(0, 4));
        end

        waitReady();
        repeat (4) @(negedge clk);
        checkOutput("tck_queue_drained", tckQ.size(), 0);
        checkOutput("rsp_queue_drained", sbQ.size(), 0);
        checkOutput("final_tap", tapState, 4'hC);
        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/jtag_scan_sequencer.md
# jtag_scan_sequencer

Host-side JTAG master that drives the team's TAP controller over TCK/TMS/TDI and collects TDO. It accepts IR-scan, DR-scan, reset and idle commands on a valid/ready port, generates TCK from the system clock, and walks the TAP through the required state sequence. Each scan shifts up to DATA_W bits LSB-first and returns the captured TDO word. It sits between a debug/host bus bridge and the chip's JTAG pins or the TAP controller instance.

## Interface
- CLK_DIV, 2: TCK half-period in CLK cycles; legal range is ≥1.
- DATA_W, 32: maximum scan length and data width; legal range is 1..64.
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  sequencer can accept a command
- CMD_OP  in  2  00 TLR reset, 01 IR scan, 10 DR scan, 11 idle clocks
- CMD_LEN  in  6  bit count minus 1; values above DATA_W-1 clamp to DATA_W-1
- CMD_DATA  in  DATA_W  TDI bits; bit 0 is shifted first
- RSP_VALID  out  1  scan result available
- RSP_READY  in  1  host accepts result
- RSP_DATA  out  DATA_W  captured TDO; bit i is sampled during shift bit i; bits above CMD_LEN are 0
- TCK  out  1  JTAG clock
- TMS  out  1  JTAG mode select
- TDI  out  1  JTAG data out
- TDO  in  1  JTAG data in
- TAP_STATE  out  4  mirrored TAP state, in the team TAP encoding
- BUSY  out  1  high whenever FSM is not IDLE

## Operation
- TAP_STATE uses the team TAP encoding: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, UpdIR D.
  - The mirror advances per the standard TAP transition graph on every TCK rise, using the current TMS.
- TCK period structure:
  - Each TCK period is 2·CLK_DIV CLK cycles: low phase first, then high phase.
  - TMS and TDI update on the first CLK of the low phase.
  - TDO is sampled on the CLK cycle where TCK goes high.
- FSM states: INIT, IDLE, HEADER, SHIFT, TRAILER, RUNIDLE, RESP.
- INIT (entered after reset and for op 00):
  - 5 TCKs with TMS=1, then 1 TCK with TMS=0.
  - TAP ends in RTI (C).
  - No response is generated.
- IDLE:
  - CMD_READY=1, TCK held 0, TMS=0, TDI=0.
  - A handshake (CMD_VALID & CMD_READY) latches op, clamped length and data. CMD_READY drops the next cycle.
- HEADER, all from RTI:
  - IR scan: TMS 1,1,0,0 → ShIR (A).
  - DR scan: TMS 1,0,0 → ShDR (2).
- SHIFT:
  - Runs LEN+1 TCKs.
  - TDI = data bit i.
  - TMS=0 on every bit except the last, which uses TMS=1 → Ex1 (9 or 1).
  - The TDO sample from bit i is written into RSP_DATA[i].
- TRAILER: TMS 1,0 → Upd (D or 5), then RTI (C).
- RUNIDLE (op 11): LEN+1 TCKs with TMS=0; the TAP stays in RTI. No response is generated.
- RESP:
  - RSP_VALID=1 and RSP_DATA stay stable until RSP_READY.
  - On the handshake the FSM returns to IDLE. No new command is accepted while RSP_VALID=1.
- TDI is driven 0 outside SHIFT.

## Timing
- Reset values, applied on the cycle after RST is sampled high:
  - TCK=0, TMS=1, TDI=0.
  - CMD_READY=0, RSP_VALID=0, RSP_DATA=0, BUSY=1.
  - TAP_STATE=F.
  - The FSM is in INIT.
- First CMD_READY=1 occurs exactly 12·CLK_DIV cycles after RST deasserts (6 TCK periods).
- Command accepted at cycle N → the first TCK low phase begins at N+1.
- Scan latency from acceptance to RSP_VALID=1 is 2·CLK_DIV·(H+L+2)+1 cycles:
  - L = clamped LEN+1.
  - H = 4 for IR scans, 3 for DR scans.
- Idle and TLR ops return to CMD_READY=1 the cycle after their last TCK period ends.
- RST mid-operation: any command in progress is aborted and RSP_VALID is dropped. The FSM restarts INIT, so the TAP is always resynchronised via TLR.
- CLK_DIV=1: TCK toggles every CLK cycle. TDO is still sampled on the rising-edge cycle.
- TCK never glitches; a phase is never shorter than CLK_DIV cycles, including across command boundaries.

## Test plan
- Reset with CLK_DIV=2 → 6 TCK pulses, TMS 1,1,1,1,1,0; TAP_STATE ends C; CMD_READY=1 at cycle 24 after RST release.
- IR scan with LEN=3, DATA=0x5, TDO looped to TDI via a 1-bit TCK-rise delay model → TMS 1,1,0,0,0,0,0,1,1,0; TAP_STATE passes A then 9 then D then C; RSP_DATA matches the model.
- DR scan with LEN=31, DATA=0xDEADBEEF, TDO=TDI combinational → RSP_DATA=0xDEADBEEF; RSP_VALID rises at cycle 2·2·37+1=149 after acceptance.
- DR scan, RSP_READY held low for 20 cycles → RSP_VALID and RSP_DATA stay stable; CMD_READY=0 throughout; single handshake; then IDLE.
- Idle op with LEN=9 → 10 TCKs with TMS=0; TAP_STATE stays C; no RSP_VALID.
- RST asserted midway through a 16-bit DR shift → RSP_VALID=0, TCK=0 next cycle, INIT sequence replays, TAP_STATE F then C.
- CLK_DIV=1, LEN=63 clamped to DATA_W-1=31 → exactly 32 shift TCKs; RSP_DATA bits are correct.
